// File: rtl/instmem_ctrl_pkg.sv
// instmem_ctrl_pkg: shared state encoding, word constants and address legality check
package instmem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;
   localparam int unsigned WORD_BYTES = 4;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   // Full 32-bit compare so addresses near 2^32 are rejected rather than wrapping.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
      return ((addr[1:0] & ALIGN_MASK) == 2'b00) && (addr <= 32'(mem_bytes - WORD_BYTES));
   endfunction
endpackage

// File: rtl/instmem_ctrl_arb.sv
// instmem_ctrl_arb: loader-priority arbiter that yields to fetch after a bounded loader streak
module instmem_ctrl_arb #(
   parameter int MAX_LOAD_BURST = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic idle,
   input  logic fetch_valid,
   input  logic load_valid,
   output logic grant_fetch,
   output logic grant_load
);
   localparam int SW = $clog2(MAX_LOAD_BURST + 1);
   logic [SW-1:0] streak;
   logic starved;
   assign starved = streak == SW'(MAX_LOAD_BURST);
   assign grant_load = idle && load_valid && !(fetch_valid && starved);
   assign grant_fetch = idle && fetch_valid && !grant_load;
   // Only loader wins over a waiting fetch count toward the streak.
   always_ff @(posedge clk or posedge reset)
      if (reset) streak <= '0;
      else if (grant_fetch) streak <= '0;
      else if (grant_load && fetch_valid && !starved) streak <= streak + SW'(1);
endmodule

// File: rtl/instmem_access_ctrl.sv
// instmem_access_ctrl: shares one instruction memory port between fetch reads and loader writes,
// sequencing each legal access as a single registered memory cycle.
module instmem_access_ctrl
   import instmem_ctrl_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int MAX_LOAD_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_addr,
   output logic        fetch_rsp_valid,
   output logic [31:0] fetch_rsp_data,
   output logic        fetch_rsp_err,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        load_done,
   output logic        load_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   state_t state, state_nxt;
   logic f_ok, l_ok, f_bad, l_bad;
   instmem_ctrl_arb #(.MAX_LOAD_BURST(MAX_LOAD_BURST)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .idle        (state == IDLE),
      .fetch_valid (fetch_valid),
      .load_valid  (load_valid),
      .grant_fetch (fetch_ready),
      .grant_load  (load_ready)
   );
   assign f_ok = addr_ok(fetch_addr, MEM_BYTES);
   assign l_ok = addr_ok(load_addr, MEM_BYTES);
   assign f_bad = fetch_ready && !f_ok;
   assign l_bad = load_ready && !l_ok;
   // Write strobe comes straight from the state register so reset drops it asynchronously.
   assign mem_we = state == LOAD;
   always_comb begin
      state_nxt = (fetch_ready && f_ok) ? FETCH : (load_ready && l_ok) ? LOAD : IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state           <= IDLE;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         fetch_rsp_valid <= 1'b0;
         fetch_rsp_err   <= 1'b0;
         fetch_rsp_data  <= '0;
         load_done       <= 1'b0;
         load_err        <= 1'b0;
      end else begin
         state           <= state_nxt;
         fetch_rsp_valid <= (state == FETCH) || f_bad;
         fetch_rsp_err   <= f_bad;
         load_done       <= (state == LOAD) || l_bad;
         load_err        <= l_bad;
         if (state == FETCH) fetch_rsp_data <= mem_rdata;
         else if (f_bad) fetch_rsp_data <= '0;
         if (state_nxt != IDLE) mem_addr <= fetch_ready ? fetch_addr : load_addr;
         if (state_nxt == LOAD) mem_wdata <= load_data;
      end
endmodule

// File: tb/tb_instmem_access_ctrl.sv
// tb_instmem_access_ctrl: scoreboard bench with a request-level reference model and memory model
module tb_instmem_access_ctrl;
   localparam int MEM_BYTES = 1024;
   localparam int MAX_LOAD_BURST = 4;
   localparam int WORDS = MEM_BYTES / 4;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0, reset = 1'b1;
   logic fetch_valid = 1'b0, load_valid = 1'b0;
   logic [31:0] fetch_addr = '0, load_addr = '0, load_data = '0;
   logic fetch_ready, fetch_rsp_valid, fetch_rsp_err, load_ready, load_done, load_err, mem_we;
   logic [31:0] fetch_rsp_data, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] env_mem [WORDS] = '{default: 32'h0};
   logic [31:0] ref_mem [WORDS] = '{default: 32'h0};
   exp_t fq[$], lq[$];
   int checks = 0, fails = 0, ncyc = 0;
   int busy_m = 0, streak_m = 0;
   logic [31:0] wa_m, wd_m;
   string grants;

   always #5 clk = ~clk;
   always @(posedge clk) ncyc++;
   always @(posedge clk) if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
   assign mem_rdata = env_mem[mem_addr[9:2]];

   instmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .MAX_LOAD_BURST(MAX_LOAD_BURST)) dut (
      .clk(clk), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
      .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data), .fetch_rsp_err(fetch_rsp_err),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
      .load_done(load_done), .load_err(load_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= MEM_BYTES - 4);
   endfunction

   function automatic logic [31:0] good_addr();
      return 32'($urandom_range(0, WORDS - 1)) * 4;
   endfunction

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      return r == 0 ? $urandom : r == 1 ? 32'($urandom_range(0, MEM_BYTES + 7)) : good_addr();
   endfunction

   // Response monitor: every cycle a response is either due exactly now or must be absent.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         if (fq.size() != 0 && fq[0].due == ncyc) begin
            e = fq.pop_front();
            chk("fetch_rsp_valid", fetch_rsp_valid, 1);
            chk("fetch_rsp_err", fetch_rsp_err, e.err);
            chk("fetch_rsp_data", fetch_rsp_data, e.data);
         end else chk("fetch_rsp_spurious", fetch_rsp_valid, 0);
         if (lq.size() != 0 && lq[0].due == ncyc) begin
            e = lq.pop_front();
            chk("load_done", load_done, 1);
            chk("load_err", load_err, e.err);
         end else chk("load_done_spurious", load_done, 0);
      end
   end

   // One request cycle: drive after the edge, judge readiness and memory side before the next edge.
   task automatic step(input logic fv, input logic [31:0] fa, input logic lv,
                       input logic [31:0] la, input logic [31:0] ld);
      bit ef, el, ok;
      @(posedge clk);
      #1;
      fetch_valid = fv; fetch_addr = fa; load_valid = lv; load_addr = la; load_data = ld;
      @(negedge clk);
      chk("mem_we", mem_we, busy_m == 2);
      if (busy_m != 0) chk("mem_addr", mem_addr, wa_m);
      if (busy_m == 2) chk("mem_wdata", mem_wdata, wd_m);
      el = busy_m == 0 && lv && !(fv && streak_m >= MAX_LOAD_BURST);
      ef = busy_m == 0 && fv && !el;
      chk("fetch_ready", fetch_ready, ef);
      chk("load_ready", load_ready, el);
      busy_m = 0;
      if (ef) begin
         streak_m = 0;
         grants = {grants, "F"};
         ok = legal(fa);
         fq.push_back('{err: !ok, data: ok ? ref_mem[fa[9:2]] : 32'h0, due: ncyc + (ok ? 2 : 1)});
         if (ok) begin busy_m = 1; wa_m = fa; end
      end
      if (el) begin
         if (fv) streak_m++;
         grants = {grants, "L"};
         ok = legal(la);
         lq.push_back('{err: !ok, data: 32'h0, due: ncyc + (ok ? 2 : 1)});
         if (ok) begin busy_m = 2; wa_m = la; wd_m = ld; ref_mem[la[9:2]] = ld; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 32'h0, 0, 32'h0, 32'h0);
   endtask

   task automatic rst_release(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      fq.delete(); lq.delete();
      busy_m = 0; streak_m = 0;
      chk("rst_ctrl_outputs", {25'h0, fetch_ready, load_ready, fetch_rsp_valid, fetch_rsp_err,
                               load_done, load_err, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_fetch_rsp_data", fetch_rsp_data, 32'h0);
   endtask

   initial begin
      logic [31:0] old;
      rst_release(3);
      idle(2);
      // write then read back
      step(0, 32'h0, 1, 32'h8, 32'hDEADBEEF);
      idle(1);
      step(1, 32'h8, 0, 32'h0, 32'h0);
      idle(2);
      // illegal addresses and the top legal word
      step(1, 32'h6, 0, 32'h0, 32'h0);
      step(0, 32'h0, 1, 32'h3FD, 32'h11111111);
      step(0, 32'h0, 1, 32'hFFFFFFFC, 32'h22222222);
      step(0, 32'h0, 1, 32'h3FC, 32'hCAFEF00D);
      idle(1);
      step(1, 32'h3FC, 0, 32'h0, 32'h0);
      step(1, 32'h400, 0, 32'h0, 32'h0);
      idle(2);
      // contention with continuous requests from both sides
      step(1, 32'h0, 0, 32'h0, 32'h0);
      idle(1);
      grants = "";
      for (int i = 0; i < 40 && grants.len() < 10; i++)
         step(1, good_addr(), 1, good_addr(), $urandom);
      checks++;
      if (grants != "LLLLFLLLLF") begin
         fails++;
         $display("FAIL grant_sequence: got %s expected LLLLFLLLLF", grants);
      end
      idle(2);
      // back-to-back fetches of known words
      for (int i = 0; i < 3; i++) begin
         step(0, 32'h0, 1, 32'(i * 4), 32'hA5000000 + 32'(i));
         idle(1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 32'(i * 4), 0, 32'h0, 32'h0);
         step(1, 32'(i * 4), 0, 32'h0, 32'h0);
      end
      idle(2);
      // randomized traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1), rand_addr(), $urandom);
      idle(3);
      // reset during a write cycle
      old = ref_mem[4];
      step(0, 32'h0, 1, 32'h10, 32'h12345678);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      chk("we_before_reset", mem_we, 1);
      reset = 1'b1;
      #1;
      chk("we_async_drop", mem_we, 0);
      rst_release(2);
      ref_mem[4] = old;
      step(1, good_addr(), 1, 32'h14, 32'h0BADCAFE);
      idle(1);
      step(1, 32'h10, 0, 32'h0, 32'h0);
      idle(3);
      chk("fetch_queue_drained", 32'(fq.size()), 32'h0);
      chk("load_queue_drained", 32'(lq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/instmem_access_ctrl.md
Name: instmem_access_ctrl

Overview:
Controller that shares the single byte-addressed, little-endian 32-bit instruction memory port between two requesters. The first requester is the CPU fetch unit (read). The second is the program loader (word write). The block arbitrates between them, enforces alignment and range rules, and sequences each access as one registered memory cycle, which gives a clean one-cycle write strobe. It sits between the fetch stage/loader and the instruction memory.

Parameters:
MEM_BYTES, 1024, memory size in bytes; must be a multiple of 4.
MAX_LOAD_BURST, 4, maximum consecutive loader grants while a fetch is waiting; must be at least 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_valid  in  1  fetch request
fetch_ready  out  1  fetch request accepted this cycle (valid&ready = transfer)
fetch_addr  in  32  fetch byte address
fetch_rsp_valid  out  1  one-cycle response pulse
fetch_rsp_data  out  32  instruction word; 0 on error
fetch_rsp_err  out  1  qualifies fetch_rsp_valid; misaligned or out of range
load_valid  in  1  loader write request
load_ready  out  1  loader request accepted this cycle
load_addr  in  32  write byte address
load_data  in  32  write word
load_done  out  1  one-cycle completion pulse
load_err  out  1  qualifies load_done; write was not performed
mem_addr  out  32  to memory address
mem_we  out  1  to memory write enable
mem_wdata  out  32  to memory write data
mem_rdata  in  32  from memory; combinational read of mem_addr

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state IDLE, streak 0. All outputs are 0: mem_addr, mem_wdata, mem_we, both ready signals, all response pulses, err flags and fetch_rsp_data.
- States:
  - IDLE: the only state that accepts requests.
  - FETCH: read cycle.
  - LOAD: write cycle.
  - Every access state returns to IDLE after exactly 1 cycle.
- Arbitration in IDLE (combinational ready):
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the loader wins, unless streak==MAX_LOAD_BURST. In that case the fetch wins.
  - At most one ready is high in any cycle. Both ready signals are 0 outside IDLE.
- Streak counter:
  - Increments on each loader grant made while fetch_valid=1.
  - Clears on any fetch grant.
  - Saturates at MAX_LOAD_BURST.
  - Width is clog2(MAX_LOAD_BURST+1).
- Validity check at accept:
  - A request is bad if addr[1:0]!=0 or addr > MEM_BYTES-4.
  - Compare against the full 32-bit address, with no wrap.
  - A bad request stays in IDLE and never drives mem_we.
  - On the next cycle it pulses fetch_rsp_valid+fetch_rsp_err (data 0) or load_done+load_err.
- Good fetch:
  - Transfer at edge N latches mem_addr and enters FETCH.
  - At edge N+1, fetch_rsp_data <= mem_rdata, fetch_rsp_valid pulses high for one cycle, and the state returns to IDLE.
  - Latency is 1 cycle after the transfer edge. Throughput is 1 access per 2 cycles.
- Good load:
  - Transfer at edge N latches mem_addr and mem_wdata and enters LOAD.
  - mem_we=1 for exactly the cycle after edge N, with addr/wdata stable for that whole cycle.
  - At edge N+1, mem_we=0, load_done pulses (err 0), and the state returns to IDLE.
- No response backpressure: requesters must sample the pulses.
- fetch_rsp_data holds its value until the next fetch response.
- mem_addr holds its last value while IDLE.
- Reset mid-operation:
  - mem_we deasserts immediately (asynchronously) and all pending pulses are dropped.
  - No done/rsp is produced for the aborted access.
  - A partially written word is not retried; the loader must reissue.
- Request inputs are ignored when the matching ready signal is 0. Address/data may change freely in that case.

Decomposition:
- Package instmem_ctrl_pkg:
  - State enum {IDLE, FETCH, LOAD}.
  - Word-size constant 4.
  - Alignment mask 2'b11.
  - Function addr_ok(addr, mem_bytes).
- One sub-module, instmem_ctrl_arb: two-requester priority arbiter with streak counter. Its inputs are idle, fetch_valid, load_valid, clk and reset. Its outputs are grant_fetch and grant_load.

Test Plan:
1. Reset: assert reset for 3 cycles, then release -> every output is 0, fetch_ready/load_ready=0 until a valid is raised.
2. Write/read-back: load 0x8 with 0xDEADBEEF -> mem_we=1 for one cycle with mem_addr=0x8 and mem_wdata=0xDEADBEEF, then load_done=1/load_err=0. Then fetch 0x8 -> fetch_rsp_valid=1 with data 0xDEADBEEF, one cycle after the transfer.
3. Bad addresses:
   - fetch 0x6 -> rsp_err=1, data 0, no access.
   - load 0x3FD and load 0xFFFFFFFC -> load_err=1 and mem_we never 1.
   - load 0x3FC -> succeeds.
4. Contention: MAX_LOAD_BURST=4, both valid continuously -> grant sequence L,L,L,L,F,L,L,L,L,F. Fetch is never starved.
5. Reset asserted mid-LOAD: mem_we falls in the same cycle, no load_done, state IDLE, streak 0. A new request is accepted on the first cycle after release.
6. Back-to-back fetches 0x0, 0x4, 0x8 with load_valid=0 -> accepts 2 cycles apart; responses return the stored words in order, one cycle after each accept.
